// File: rtl/cross_bar_pkg.sv
// Shared sizing, types and pointer helper for the response crossbar.
package cross_bar_pkg;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned NUM_BANK    = 4;
    localparam int unsigned QUEUE_DEPTH = 5;
    localparam int unsigned DW          = 64;
    localparam int unsigned EW          = $clog2(QUEUE_DEPTH);
    localparam int unsigned CHW         = 2;
    localparam int unsigned BW          = $clog2(NUM_BANK);
    localparam int unsigned CW          = $clog2(QUEUE_DEPTH + 1);

    typedef logic [CHW-1:0] chid_t;
    typedef logic [EW-1:0]  entry_t;
    typedef logic [BW-1:0]  bank_idx_t;
    typedef logic [CW-1:0]  cnt_t;

    typedef struct packed {
        chid_t           chid;
        entry_t          entry;
        logic [DW-1:0]   data;
    } bank_resp_t;

    // ROB pointers wrap at QUEUE_DEPTH, which need not be a power of two.
    function automatic entry_t entry_inc(input entry_t p);
        return (p == entry_t'(QUEUE_DEPTH - 1)) ? '0 : entry_t'(p + 1'b1);
    endfunction

endpackage

// File: rtl/cross_bar_resp_rob.sv
// One channel's reorder buffer plus the round-robin arbiter choosing which
// bank response it accepts each cycle.
module cross_bar_resp_rob
    import cross_bar_pkg::*;
#(
    parameter int unsigned CH = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc,
    input  logic       [NUM_BANK-1:0]  bank_valid,
    input  bank_resp_t [NUM_BANK-1:0]  bank_resp,
    output logic       [NUM_BANK-1:0]  grant,
    output logic                       resp_valid,
    output logic       [DW-1:0]        resp_data,
    input  logic                       resp_ready,
    output logic                       err
);

    localparam cnt_t DEPTH_CNT = cnt_t'(QUEUE_DEPTH);

    logic [QUEUE_DEPTH-1:0] pending_q, pending_d;
    logic [QUEUE_DEPTH-1:0] done_q, done_d;
    entry_t                 alloc_ptr_q, alloc_ptr_d;
    entry_t                 pop_ptr_q, pop_ptr_d;
    cnt_t                   cnt_q, cnt_d;
    bank_idx_t              rr_q, rr_d;
    logic [DW-1:0]          data_q [QUEUE_DEPTH];

    logic [NUM_BANK-1:0] req;
    logic                gnt_any;
    bank_idx_t           gnt_idx;
    entry_t              wr_entry;
    logic [DW-1:0]       wr_data;
    logic                wr_ok;
    logic                alloc_ok;
    logic                pop;

    always_comb begin
        req = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            req[b] = bank_valid[b] && (bank_resp[b].chid == chid_t'(CH));
        end
    end

    // Scan from rr_q upward; the 2-bit add wraps naturally over the banks.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_BANK; i++) begin
            if (!gnt_any && req[bank_idx_t'(rr_q + bank_idx_t'(i))]) begin
                gnt_any = 1'b1;
                gnt_idx = bank_idx_t'(rr_q + bank_idx_t'(i));
            end
        end
        grant = '0;
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
        rr_d = gnt_any ? bank_idx_t'(gnt_idx + 1'b1) : rr_q;
    end

    assign wr_entry   = bank_resp[gnt_idx].entry;
    assign wr_data    = bank_resp[gnt_idx].data;
    assign wr_ok      = gnt_any && (wr_entry < entry_t'(QUEUE_DEPTH))
                        && pending_q[wr_entry] && !done_q[wr_entry];
    assign resp_valid = pending_q[pop_ptr_q] & done_q[pop_ptr_q];
    assign resp_data  = data_q[pop_ptr_q];
    assign pop        = resp_valid & resp_ready;
    assign alloc_ok   = alloc && (cnt_q < DEPTH_CNT);
    assign err        = (alloc && !alloc_ok) || (gnt_any && !wr_ok);

    always_comb begin
        pending_d   = pending_q;
        done_d      = done_q;
        alloc_ptr_d = alloc_ptr_q;
        pop_ptr_d   = pop_ptr_q;
        cnt_d       = cnt_q;
        if (pop) begin
            pending_d[pop_ptr_q] = 1'b0;
            done_d[pop_ptr_q]    = 1'b0;
            pop_ptr_d            = entry_inc(pop_ptr_q);
        end
        if (wr_ok) begin
            done_d[wr_entry] = 1'b1;
        end
        // A full buffer rejects alloc even if the head pops this same cycle.
        if (alloc_ok) begin
            pending_d[alloc_ptr_q] = 1'b1;
            alloc_ptr_d            = entry_inc(alloc_ptr_q);
        end
        case ({alloc_ok, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            done_q      <= '0;
            alloc_ptr_q <= '0;
            pop_ptr_q   <= '0;
            cnt_q       <= '0;
            rr_q        <= '0;
        end else begin
            pending_q   <= pending_d;
            done_q      <= done_d;
            alloc_ptr_q <= alloc_ptr_d;
            pop_ptr_q   <= pop_ptr_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            data_q[wr_entry] <= wr_data;
        end
    end

endmodule

// File: rtl/cross_bar_resp.sv
// Response crossbar: routes bank responses into per-channel reorder buffers
// and returns them to each channel in request order.
module cross_bar_resp
    import cross_bar_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_CH-1:0]             ch_alloc_i,
    input  logic [NUM_BANK-1:0]           bank_resp_valid_i,
    output logic [NUM_BANK-1:0]           bank_resp_ready_o,
    input  logic [NUM_BANK-1:0][CHW-1:0]  bank_resp_chid_i,
    input  logic [NUM_BANK-1:0][EW-1:0]   bank_resp_entry_i,
    input  logic [NUM_BANK-1:0][DW-1:0]   bank_resp_data_i,
    output logic [NUM_CH-1:0]             ch_resp_valid_o,
    input  logic [NUM_CH-1:0]             ch_resp_ready_i,
    output logic [NUM_CH-1:0][DW-1:0]     ch_resp_data_o,
    output logic                          err_o
);

    bank_resp_t [NUM_BANK-1:0]             bank_resp;
    logic       [NUM_CH-1:0][NUM_BANK-1:0] ch_grant;
    logic       [NUM_CH-1:0]               ch_err;
    logic       [NUM_BANK-1:0]             bad_chid;
    logic                                  err_q;

    always_comb begin
        bank_resp = '0;
        bad_chid  = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_resp[b].chid  = bank_resp_chid_i[b];
            bank_resp[b].entry = bank_resp_entry_i[b];
            bank_resp[b].data  = bank_resp_data_i[b];
            bad_chid[b] = bank_resp_valid_i[b] && (bank_resp_chid_i[b] >= chid_t'(NUM_CH));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_rob
        cross_bar_resp_rob #(
            .CH(c)
        ) u_rob (
            .clk        (clk_i),
            .rst_n      (rstn_i),
            .alloc      (ch_alloc_i[c]),
            .bank_valid (bank_resp_valid_i),
            .bank_resp  (bank_resp),
            .grant      (ch_grant[c]),
            .resp_valid (ch_resp_valid_o[c]),
            .resp_data  (ch_resp_data_o[c]),
            .resp_ready (ch_resp_ready_i[c]),
            .err        (ch_err[c])
        );
    end

    // Responses to a nonexistent channel are drained so the bank never stalls.
    always_comb begin
        bank_resp_ready_o = bad_chid;
        for (int c = 0; c < NUM_CH; c++) begin
            bank_resp_ready_o = bank_resp_ready_o | ch_grant[c];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q <= 1'b0;
        end else if ((|ch_err) || (|bad_chid)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_cross_bar_resp.sv
// Scoreboard bench for cross_bar_resp: directed scenarios plus randomized traffic.
module tb_cross_bar_resp;
    import cross_bar_pkg::*;

    logic                          clk = 1'b0;
    logic                          rstn;
    logic [NUM_CH-1:0]             ch_alloc;
    logic [NUM_BANK-1:0]           bank_valid;
    logic [NUM_BANK-1:0]           bank_ready;
    logic [NUM_BANK-1:0][CHW-1:0]  bank_chid;
    logic [NUM_BANK-1:0][EW-1:0]   bank_entry;
    logic [NUM_BANK-1:0][DW-1:0]   bank_data;
    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH-1:0]             ch_ready;
    logic [NUM_CH-1:0][DW-1:0]     ch_data;
    logic                          err;

    always #5 clk = ~clk;

    cross_bar_resp u_dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .ch_alloc_i        (ch_alloc),
        .bank_resp_valid_i (bank_valid),
        .bank_resp_ready_o (bank_ready),
        .bank_resp_chid_i  (bank_chid),
        .bank_resp_entry_i (bank_entry),
        .bank_resp_data_i  (bank_data),
        .ch_resp_valid_o   (ch_valid),
        .ch_resp_ready_i   (ch_ready),
        .ch_resp_data_o    (ch_data),
        .err_o             (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: slot state 0 free, 1 allocated, 2 response in flight, 3 done.
    int            slot_st   [NUM_CH][QUEUE_DEPTH];
    logic [63:0]   slot_data [NUM_CH][QUEUE_DEPTH];
    int            order_q   [NUM_CH][$];
    int            next_alloc[NUM_CH];
    int            rr        [NUM_CH];
    logic          exp_err;
    logic [NUM_CH-1:0] alloc_req;

    logic          bv    [NUM_BANK];
    int            bch   [NUM_BANK];
    int            bent  [NUM_BANK];
    logic [63:0]   bdat  [NUM_BANK];
    logic          bbog  [NUM_BANK];

    typedef struct {
        int          c;
        int          s;
        logic [63:0] d;
    } mark_t;
    mark_t marks[$];
    int    grant_log[$];

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send(input int b, input int c, input int e, input logic [63:0] d);
        bv[b]   = 1'b1;
        bch[b]  = c;
        bent[b] = e;
        bdat[b] = d;
        bbog[b] = 1'b1;
        if (c < NUM_CH && e < QUEUE_DEPTH) begin
            if (slot_st[c][e] == 1 || slot_st[c][e] == 2) begin
                bbog[b] = 1'b0;
                slot_st[c][e] = 2;
            end
        end
    endtask

    // One clock cycle; entered and left just after a rising edge.
    task automatic tick();
        mark_t             m;
        logic [NUM_BANK-1:0] exp_rdy;
        int                b;
        logic              found;
        while (marks.size() > 0) begin
            m = marks.pop_front();
            slot_st[m.c][m.s]   = 3;
            slot_data[m.c][m.s] = m.d;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (alloc_req[c]) begin
                if (order_q[c].size() < QUEUE_DEPTH) begin
                    order_q[c].push_back(next_alloc[c]);
                    slot_st[c][next_alloc[c]] = 1;
                    next_alloc[c] = (next_alloc[c] + 1) % QUEUE_DEPTH;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        ch_alloc = alloc_req;
        for (int k = 0; k < NUM_BANK; k++) begin
            bank_valid[k] = bv[k];
            bank_chid[k]  = bch[k][CHW-1:0];
            bank_entry[k] = bent[k][EW-1:0];
            bank_data[k]  = bdat[k];
        end
        @(negedge clk);
        exp_rdy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_BANK; i++) begin
                b = (rr[c] + i) % NUM_BANK;
                if (!found && bv[b] && bch[b] == c) begin
                    found      = 1'b1;
                    exp_rdy[b] = 1'b1;
                    rr[c]      = (b + 1) % NUM_BANK;
                    grant_log.push_back(b);
                end
            end
        end
        for (int k = 0; k < NUM_BANK; k++) begin
            if (bv[k] && bch[k] >= NUM_CH) exp_rdy[k] = 1'b1;
        end
        check("bank_ready", bank_ready, exp_rdy);
        for (int k = 0; k < NUM_BANK; k++) begin
            if (exp_rdy[k]) begin
                if (bbog[k]) exp_err = 1'b1;
                else marks.push_back('{c: bch[k], s: bent[k], d: bdat[k]});
                bv[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        alloc_req = '0;
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        ch_alloc   = '0;
        bank_valid = '0;
        bank_chid  = '0;
        bank_entry = '0;
        bank_data  = '0;
        ch_ready   = '0;
        alloc_req  = '0;
        exp_err    = 1'b0;
        marks.delete();
        grant_log.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            order_q[c].delete();
            next_alloc[c] = 0;
            rr[c] = 0;
            for (int s = 0; s < QUEUE_DEPTH; s++) slot_st[c][s] = 0;
        end
        for (int k = 0; k < NUM_BANK; k++) begin
            bv[k] = 1'b0; bch[k] = 0; bent[k] = 0; bdat[k] = '0; bbog[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bank_ready", bank_ready, '0);
        check("rst_ch_valid", ch_valid, '0);
        check("rst_err", err, exp_err);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: expected head validity and in-order delivery.
    always @(negedge clk) begin
        int   s;
        logic ev;
        if (rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ev = (order_q[c].size() > 0) && (slot_st[c][order_q[c][0]] == 3);
                check("ch_valid", ch_valid[c], ev);
                if (ch_valid[c] && ch_ready[c]) begin
                    if (order_q[c].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ch_pop_empty: channel %0d popped with no outstanding entry", c);
                    end else begin
                        s = order_q[c].pop_front();
                        check("ch_data", ch_data[c], slot_data[c][s]);
                        slot_st[c][s] = 0;
                    end
                end
            end
        end
    end

    task automatic random_cycles(input int n, input logic drain);
        int c;
        int st;
        int s;
        logic sent;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                alloc_req[k] = !drain && ($urandom_range(0, 2) == 0)
                               && (order_q[k].size() < QUEUE_DEPTH);
            end
            for (int b = 0; b < NUM_BANK; b++) begin
                if (!bv[b] && $urandom_range(0, 1) == 1) begin
                    c    = $urandom_range(0, NUM_CH - 1);
                    st   = $urandom_range(0, QUEUE_DEPTH - 1);
                    sent = 1'b0;
                    for (int k = 0; k < QUEUE_DEPTH; k++) begin
                        s = (st + k) % QUEUE_DEPTH;
                        if (!sent && slot_st[c][s] == 1) begin
                            send(b, c, s, rnd64());
                            sent = 1'b1;
                        end
                    end
                end
            end
            ch_ready = drain ? '1 : NUM_CH'($urandom);
            tick();
        end
    endtask

    initial begin
        int outstanding;
        logic [63:0] held;
        #200_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        int          outstanding;

        // Reset and idle
        do_reset();
        repeat (2) tick();

        // Out-of-order responses on ch0 delivered in push order
        ch_ready = 3'b001;
        alloc_req = 3'b001; tick();
        alloc_req = 3'b001; tick();
        send(1, 0, 1, 64'hB); tick();
        send(0, 0, 0, 64'hA); tick();
        repeat (4) tick();

        // Four banks contend for ch2: round-robin order, twice
        do_reset();
        ch_ready = 3'b100;
        for (int i = 0; i < 4; i++) begin alloc_req = 3'b100; tick(); end
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < NUM_BANK; b++) send(b, 2, (r * 4 + b) % QUEUE_DEPTH, rnd64());
            grant_log.delete();
            repeat (4) tick();
            for (int i = 0; i < 4; i++) begin
                if (grant_log.size() > i) check("rr_order", bank_ready, bank_ready);
            end
            check("rr_count", grant_log.size(), 4);
            for (int i = 0; i < grant_log.size() && i < 4; i++) check("rr_order", grant_log[i], i);
            repeat (6) tick();
            if (r == 0) for (int i = 0; i < 4; i++) begin alloc_req = 3'b100; tick(); end
        end

        // Fill ch1, overflow alloc, then drain across the pointer wrap
        do_reset();
        ch_ready = 3'b010;
        for (int i = 0; i < 6; i++) begin alloc_req = 3'b010; tick(); end
        tick();
        check("err_full", err, exp_err);
        for (int s = 0; s < QUEUE_DEPTH; s++) begin send(s % NUM_BANK, 1, s, rnd64()); tick(); end
        repeat (8) tick();
        alloc_req = 3'b010; tick();
        send(2, 1, 0, 64'h5A5A); tick();
        repeat (3) tick();
        check("err_sticky", err, 1'b1);

        // Response to a non-pending entry and to a nonexistent channel
        do_reset();
        ch_ready = 3'b000;
        alloc_req = 3'b001; tick();
        send(0, 0, 0, 64'hA0A0); tick();
        tick();
        check("err_clean", err, exp_err);
        send(2, 0, 3, 64'hDEAD); tick();
        tick();
        check("err_nonpending", err, exp_err);
        check("hold_after_bogus", ch_data[0], 64'hA0A0);
        do_reset();
        send(1, 3, 0, 64'hBEEF); tick();
        tick();
        check("err_bad_chid", err, exp_err);

        // Output hold under back-pressure, then reset mid-stream
        do_reset();
        ch_ready = 3'b000;
        alloc_req = 3'b010; tick();
        alloc_req = 3'b010; tick();
        held = rnd64();
        send(3, 1, 0, held); tick();
        send(3, 1, 1, rnd64()); tick();
        for (int i = 0; i < 3; i++) begin
            check("hold_data", ch_data[1], held);
            tick();
        end
        rstn = 1'b0;
        #1;
        check("rst_valid_drop", ch_valid, '0);
        do_reset();
        repeat (3) tick();

        // Randomized traffic, then drain
        do_reset();
        random_cycles(2000, 1'b0);
        random_cycles(300, 1'b1);
        outstanding = 0;
        for (int c = 0; c < NUM_CH; c++) outstanding += order_q[c].size();
        check("drain_done", outstanding, 0);
        check("err_random", err, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
